// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the spiking-network epoch sequencer.
// Holds the controller state encoding, default network widths and the accuracy scale.
// Optional feature macro used by the sequencer: SNN_SEQ_ACCURACY_EN (adds the DIV state).
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRIVE = 3'd2,
    DRAIN = 3'd3,
    DIV   = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  localparam int NUM_IN_DEF  = 6;
  localparam int NUM_OUT_DEF = 3;
  localparam int ADDR_W_DEF  = 4;

  // Accuracy is reported as an integer percentage.
  localparam int ACC_SCALE = 100;
  localparam int ACC_W     = 7;

endpackage

// File: rtl/snn_exp_delay_line.sv
// Aligns each expected pattern with the network output: LATENCY-deep shift register of
// {valid, pattern}. Latency is exactly LATENCY shifts; it only advances while shift_i is high.
// Ports: clock, reset (async active-low clear), shift_i, in_vld_i/in_dat_i, out_vld_o/out_dat_o.
module snn_exp_delay_line
  import snn_ctrl_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int NUM_OUT = NUM_OUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               shift_i,
  input  logic               in_vld_i,
  input  logic [NUM_OUT-1:0] in_dat_i,
  output logic               out_vld_o,
  output logic [NUM_OUT-1:0] out_dat_o
);

  logic [NUM_OUT:0] stage_q [LATENCY];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else if (shift_i) begin
      stage_q[0] <= {in_vld_i, in_dat_i};
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {out_vld_o, out_dat_o} = stage_q[LATENCY-1];

endmodule

// File: rtl/snn_epoch_sequencer.sv
// Runs one epoch: reads (input, expected) pairs from pattern memory, drives the network,
// aligns expected patterns with the network latency and counts matches.
// Ports: clock/reset (async active-low), start/mode request, busy/done/learn_en status,
// mem_rd/mem_addr/mem_inp/mem_exp memory side, nn_inp/nn_outp network side,
// match_count/accuracy results. Macro SNN_SEQ_ACCURACY_EN adds the DIV state and a
// registered accuracy percentage; without it accuracy is tied to 0.
module snn_epoch_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_IN      = NUM_IN_DEF,
  parameter int NUM_OUT     = NUM_OUT_DEF,
  parameter int NUM_SAMPLES = 15,
  parameter int HOLD_CYCLES = 1,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CNT_W       = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic               learn_en,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [NUM_IN-1:0]  mem_inp,
  input  logic [NUM_OUT-1:0] mem_exp,
  output logic [NUM_IN-1:0]  nn_inp,
  input  logic [NUM_OUT-1:0] nn_outp,
  output logic [CNT_W-1:0]   match_count,
  output logic [ACC_W-1:0]   accuracy
);

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  seq_state_e          state_q;
  logic                mode_q;
  logic                busy_q;
  logic                done_q;
  logic                learn_q;
  logic                mem_rd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_IN-1:0]   nn_inp_q;
  logic [CNT_W-1:0]    match_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [DRAIN_W-1:0]  drain_q;

  logic                dl_shift;
  logic                dl_in_vld;
  logic [NUM_OUT-1:0]  dl_in_dat;
  logic                dl_out_vld;
  logic [NUM_OUT-1:0]  dl_out_dat;
  logic                hit;

  // Memory data for a sample is present in the first DRIVE cycle; that is the only
  // cycle that launches a valid expected pattern into the alignment line.
  assign dl_shift  = (state_q == FETCH) || (state_q == DRIVE) || (state_q == DRAIN);
  assign dl_in_vld = (state_q == DRIVE) && (hold_q == '0);
  assign dl_in_dat = dl_in_vld ? mem_exp : '0;

  snn_exp_delay_line #(
    .LATENCY (LATENCY),
    .NUM_OUT (NUM_OUT)
  ) u_delay (
    .clock     (clock),
    .reset     (reset),
    .shift_i   (dl_shift),
    .in_vld_i  (dl_in_vld),
    .in_dat_i  (dl_in_dat),
    .out_vld_o (dl_out_vld),
    .out_dat_o (dl_out_dat)
  );

  // All-zero expected patterns carry no spike information and are never scored.
  assign hit = dl_out_vld && (nn_outp == dl_out_dat) && (dl_out_dat != '0);

`ifdef SNN_SEQ_ACCURACY_EN
  localparam int REM_W = $clog2(ACC_SCALE * NUM_SAMPLES + 1);

  logic [REM_W-1:0] rem_q;
  logic [ACC_W-1:0] quot_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] match_d;
  logic [REM_W-1:0] rem_d;

  // The last compare can land in the final DRAIN cycle, so the dividend is taken from
  // the count including that cycle's hit.
  assign match_d = match_q + CNT_W'(hit);
  assign rem_d   = REM_W'(match_d) * REM_W'(ACC_SCALE);
  assign accuracy = acc_q;
`else
  assign accuracy = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      learn_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      addr_q   <= '0;
      nn_inp_q <= '0;
      match_q  <= '0;
      hold_q   <= '0;
      drain_q  <= '0;
`ifdef SNN_SEQ_ACCURACY_EN
      rem_q    <= '0;
      quot_q   <= '0;
      acc_q    <= '0;
`endif
    end else begin
      if (hit) match_q <= match_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= FETCH;
            mode_q   <= mode;
            busy_q   <= 1'b1;
            learn_q  <= mode;
            mem_rd_q <= 1'b1;
            addr_q   <= '0;
            match_q  <= '0;
            nn_inp_q <= '0;
`ifdef SNN_SEQ_ACCURACY_EN
            acc_q    <= '0;
`endif
          end
        end

        FETCH: begin
          mem_rd_q <= 1'b0;
          nn_inp_q <= '0;
          hold_q   <= '0;
          state_q  <= DRIVE;
        end

        DRIVE: begin
          if (hold_q == '0) nn_inp_q <= mem_inp;
          if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_q <= '0;
            if (addr_q == ADDR_W'(NUM_SAMPLES - 1)) begin
              drain_q <= '0;
              state_q <= DRAIN;
            end else begin
              addr_q   <= addr_q + 1'b1;
              mem_rd_q <= 1'b1;
              state_q  <= FETCH;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end

        DRAIN: begin
          nn_inp_q <= '0;
          if (drain_q == DRAIN_W'(LATENCY - 1)) begin
            drain_q <= '0;
            learn_q <= 1'b0;
`ifdef SNN_SEQ_ACCURACY_EN
            rem_q   <= rem_d;
            quot_q  <= '0;
            state_q <= DIV;
`else
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`endif
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end

`ifdef SNN_SEQ_ACCURACY_EN
        DIV: begin
          // Restoring division by repeated subtraction; exits as soon as the
          // remainder drops below the divisor.
          if (rem_q >= REM_W'(NUM_SAMPLES)) begin
            rem_q  <= rem_q - REM_W'(NUM_SAMPLES);
            quot_q <= quot_q + 1'b1;
          end else begin
            acc_q   <= quot_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
`endif

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign learn_en    = learn_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = addr_q;
  assign nn_inp      = nn_inp_q;
  assign match_count = match_q;

endmodule

// File: tb/tb_snn_epoch_sequencer.sv
// Scoreboard bench for snn_epoch_sequencer: the driver pushes the expected epoch result
// when it issues start, and a negedge monitor pops and compares on every done pulse.
module tb_snn_epoch_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic       busy;
  logic       done;
  logic       learn_en;
  logic       mem_rd;
  logic [3:0] mem_addr;
  logic [5:0] mem_inp;
  logic [2:0] mem_exp;
  logic [5:0] nn_inp;
  logic [2:0] nn_outp;
  logic [3:0] match_count;
  logic [6:0] accuracy;

  snn_epoch_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .busy        (busy),
    .done        (done),
    .learn_en    (learn_en),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_inp     (mem_inp),
    .mem_exp     (mem_exp),
    .nn_inp      (nn_inp),
    .nn_outp     (nn_outp),
    .match_count (match_count),
    .accuracy    (accuracy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

`ifdef SNN_SEQ_ACCURACY_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pattern memory: sample i has input pattern i+1; expected pattern from exp_tab.
  logic [2:0] exp_tab [15];
  // Network model truth table indexed by input pattern - 1.
  logic [2:0] net_tab [15];

  always @(posedge clock) begin
    if (mem_rd) begin
      mem_inp <= {2'b00, mem_addr} + 6'd1;
      mem_exp <= exp_tab[mem_addr];
    end
  end

  // The network responds one cycle after its registered input, so its answer lands
  // LATENCY cycles after the DRIVE cycle that launched the sample.
  always @(posedge clock) begin
    if (nn_inp != 6'd0 && nn_inp <= 6'd15) nn_outp <= net_tab[int'(nn_inp) - 1];
    else                                    nn_outp <= 3'd0;
  end

  typedef struct {
    int m;
    int acc;
    int learn;
  } exp_t;

  exp_t sb[$];

  int cyc       = 0;
  int ep_start  = 0;
  int learn_cnt = 0;
  int learn_bad = 0;
  int done_cnt  = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    int   len;
    cyc++;
    if (!reset) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_single_cycle", done, 0);
      if (busy && !prev_busy) begin
        ep_start  = cyc;
        learn_cnt = 0;
        learn_bad = 0;
        chk("first_cycle_mem_rd", mem_rd, 1);
        chk("first_cycle_addr", mem_addr, 0);
        chk("first_cycle_match", match_count, 0);
      end
      if (learn_en) begin
        if (busy) learn_cnt++;
        else      learn_bad++;
      end
      if (done) begin
        done_cnt++;
        chk("done_has_expectation", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e   = sb.pop_front();
          len = cyc - ep_start + 1;
          chk("match_count", match_count, e.m);
          chk("accuracy", accuracy, e.acc);
          chk("learn_en_cycles", learn_cnt, e.learn);
          chk("learn_en_outside_epoch", learn_bad, 0);
          chk("busy_at_done", busy, 0);
          if (ACC_ON) chk("epoch_len_bounded", (len >= 34 && len <= 134), 1);
          else        chk("epoch_len", len, 33);
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  // kind 0: perfect, 1: samples 0-4 corrupted, 2: samples 3/7/11 expect zero.
  task automatic load_tables(input int kind);
    for (int i = 0; i < 15; i++) begin
      logic [2:0] e;
      e = 3'((i % 7) + 1);
      exp_tab[i] = e;
      net_tab[i] = e;
      if (kind == 1 && i < 5) net_tab[i] = e ^ 3'b111;
      if (kind == 2 && (i == 3 || i == 7 || i == 11)) begin
        exp_tab[i] = 3'd0;
        net_tab[i] = 3'd0;
      end
    end
  endtask

  task automatic run_epoch(input logic m, input int exp_m, input int exp_acc, input bit poke);
    exp_t e;
    int   d0;
    int   n;
    e.m     = exp_m;
    e.acc   = ACC_ON ? exp_acc : 0;
    e.learn = m ? 32 : 0;
    sb.push_back(e);
    d0 = done_cnt;
    @(negedge clock);
    mode  = m;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (poke) begin
      // Mode must already be latched; a start while busy must be ignored.
      mode = ~m;
      repeat (8) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("epoch_completed", done_cnt != d0, 1);
    repeat (4) @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_learn_en", learn_en, 0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_learn_en"}, learn_en, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_nn_inp"}, nn_inp, 0);
    chk({tag, "_match_count"}, match_count, 0);
    chk({tag, "_accuracy"}, accuracy, 0);
  endtask

  initial begin
    int n;
    reset   = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    mem_inp = '0;
    mem_exp = '0;
    nn_outp = '0;
    load_tables(0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("reset");

    // Perfect network, test mode.
    load_tables(0);
    run_epoch(1'b0, 15, 100, 1'b0);

    // Samples 0-4 wrong, train mode, start poked while busy and mode flipped mid-run.
    load_tables(1);
    run_epoch(1'b1, 10, 66, 1'b1);

    // Reset while fetching sample 7: epoch aborted, no done, no scoreboard entry.
    load_tables(0);
    @(negedge clock);
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (mem_addr != 4'd7 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("abort_reached_addr7", mem_addr, 7);
    chk("abort_partial_count", match_count, 6);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_stays_idle", busy, 0);

    // Zero-expected samples are excluded from the score.
    load_tables(2);
    run_epoch(1'b0, 12, 80, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
